// File: rtl/parking_pkg.sv
// Shared definitions for the parking barrier lane controller.
package parking_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE     = 2'b00;
   localparam state_t OPEN_IN  = 2'b01;
   localparam state_t OPEN_OUT = 2'b10;
   localparam state_t CLOSING  = 2'b11;

   localparam int CAPACITY_DEF = 16;

endpackage

// File: rtl/occupancy_counter.sv
// Saturating up/down occupancy counter; simultaneous inc and dec cancel.
module occupancy_counter #(
   parameter int CAPACITY = 16,
   parameter int CNT_W    = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             full
);

   assign full = (count == CNT_W'(CAPACITY));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (inc && !dec && !full) begin
         count <= count + CNT_W'(1);
      end else if (dec && !inc && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Barrier lane controller: arbitrates entry/exit ownership, times the open
// window and the closing guard, and tracks lot occupancy.
//
// state    | meaning
// IDLE     | gate closed, arbitrating pending/incoming requests
// OPEN_IN  | gate open for the entry side, waiting for passage or timeout
// OPEN_OUT | gate open for the exit side, waiting for passage or timeout
// CLOSING  | gate lowering for CLOSE_CYC cycles; last cycle may grant again
module parking_gate_ctrl
   import parking_pkg::*;
#(
   parameter int CAPACITY  = CAPACITY_DEF,
   parameter int CNT_W     = 5,
   parameter int TIMEOUT   = 100,
   parameter int TMR_W     = 8,
   parameter int CLOSE_CYC = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_in,
   input  logic             req_out,
   input  logic             entrada,
   input  logic             salida,
   output logic             gate_open,
   output logic             dir_in,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             deny,
   output logic             timeout
);

   localparam int CLS_W = (CLOSE_CYC > 1) ? $clog2(CLOSE_CYC) : 1;

   state_t           state, state_nx;
   logic             pend_in, pend_out, last_dir;
   logic [TMR_W-1:0] tmr;
   logic [CLS_W-1:0] cls;

   logic eff_in, eff_out, can_grant, grant_in, grant_out, drop_in;
   logic passage, tmr_done, cls_done, is_open;
   logic gate_nx, dir_nx, deny_nx, timeout_nx;

   occupancy_counter #(
      .CAPACITY (CAPACITY),
      .CNT_W    (CNT_W)
   ) u_occupancy (
      .clk   (clk),
      .reset (reset),
      .inc   (entrada),
      .dec   (salida),
      .count (count),
      .full  (full)
   );

   // Arbitration runs in IDLE and on the final CLOSING cycle, so the next
   // grant can land on the edge that ends the closing guard.
   always_comb begin
      eff_in    = pend_in | req_in;
      eff_out   = pend_out | req_out;
      passage   = entrada | salida;
      tmr_done  = (tmr == '0);
      cls_done  = (cls == '0);
      is_open   = (state == OPEN_IN) || (state == OPEN_OUT);
      can_grant = (state == IDLE) || ((state == CLOSING) && cls_done);
      grant_in  = can_grant && eff_in && !full && !(eff_out && last_dir);
      grant_out = can_grant && eff_out && !grant_in;
      drop_in   = can_grant && eff_in && full;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         gate_open <= 1'b0;
         dir_in    <= 1'b0;
         deny      <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_nx;
         gate_open <= gate_nx;
         dir_in    <= dir_nx;
         deny      <= deny_nx;
         timeout   <= timeout_nx;
      end
   end

   always_comb begin
      state_nx = IDLE;
      case (state)
         IDLE: begin
            if (grant_in)       state_nx = OPEN_IN;
            else if (grant_out) state_nx = OPEN_OUT;
            else                state_nx = IDLE;
         end
         OPEN_IN, OPEN_OUT: begin
            state_nx = (passage || tmr_done) ? CLOSING : state;
         end
         CLOSING: begin
            if (!cls_done)      state_nx = CLOSING;
            else if (grant_in)  state_nx = OPEN_IN;
            else if (grant_out) state_nx = OPEN_OUT;
            else                state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      gate_nx    = (state_nx == OPEN_IN) || (state_nx == OPEN_OUT);
      dir_nx     = 1'b0;
      case (state_nx)
         OPEN_IN: dir_nx = 1'b1;
         CLOSING: dir_nx = dir_in;
         default: dir_nx = 1'b0;
      endcase
      timeout_nx = is_open && tmr_done && !passage;
      deny_nx    = (req_in && full) || drop_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_in  <= 1'b0;
         pend_out <= 1'b0;
         last_dir <= 1'b0;
         tmr      <= '0;
         cls      <= '0;
      end else begin
         if (grant_in || drop_in)   pend_in <= 1'b0;
         else if (req_in && !full)  pend_in <= 1'b1;

         if (grant_out)             pend_out <= 1'b0;
         else if (req_out)          pend_out <= 1'b1;

         if (grant_in)              last_dir <= 1'b1;
         else if (grant_out)        last_dir <= 1'b0;

         if (grant_in || grant_out)      tmr <= TMR_W'(TIMEOUT - 1);
         else if (is_open && !tmr_done)  tmr <= tmr - TMR_W'(1);

         if ((state != CLOSING) && (state_nx == CLOSING))
            cls <= CLS_W'(CLOSE_CYC - 1);
         else if ((state == CLOSING) && !cls_done)
            cls <= cls - CLS_W'(1);
      end
   end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// and a randomized run compared against a behavioural lane model.
module tb_parking_gate_ctrl;

   localparam int CAP = 16;
   localparam int TO  = 100;
   localparam int CLS = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       req_in = 1'b0, req_out = 1'b0, entrada = 1'b0, salida = 1'b0;
   logic       gate_open, dir_in, full, deny, timeout;
   logic [4:0] count;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   parking_gate_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .req_in    (req_in),
      .req_out   (req_out),
      .entrada   (entrada),
      .salida    (salida),
      .gate_open (gate_open),
      .dir_in    (dir_in),
      .count     (count),
      .full      (full),
      .deny      (deny),
      .timeout   (timeout)
   );

   // Behavioural lane model: gate ownership, open age, closing cycles left.
   int m_occ;
   bit m_pin, m_pout, m_last_entry, m_opened, m_owner_in, m_deny, m_to;
   int m_age, m_close_left;

   function automatic void model_reset();
      m_occ = 0; m_pin = 0; m_pout = 0; m_last_entry = 0;
      m_opened = 0; m_owner_in = 0; m_deny = 0; m_to = 0;
      m_age = 0; m_close_left = 0;
   endfunction

   function automatic void model_step(bit ri, bit ro, bit en, bit sa);
      bit full_now = (m_occ == CAP);
      bit window   = !m_opened && (m_close_left <= 1);
      bit want_in  = m_pin || ri;
      bit want_out = m_pout || ro;
      bit g_in = 0, g_out = 0, drop = 0;
      if (window) begin
         if (want_in && !full_now && !(want_out && m_last_entry)) g_in = 1;
         else if (want_out) g_out = 1;
         drop = want_in && full_now;
      end
      m_deny = (ri && full_now) || drop;
      m_to   = 0;
      if (g_in || drop) m_pin = 0; else if (ri && !full_now) m_pin = 1;
      if (g_out) m_pout = 0; else if (ro) m_pout = 1;
      if (g_in || g_out) begin
         m_opened = 1; m_owner_in = g_in; m_age = 0; m_close_left = 0;
         m_last_entry = g_in;
      end else if (m_opened) begin
         if (en || sa) begin
            m_opened = 0; m_close_left = CLS;
         end else if (m_age == TO - 1) begin
            m_opened = 0; m_close_left = CLS; m_to = 1;
         end else begin
            m_age++;
         end
      end else if (m_close_left > 0) begin
         m_close_left--;
      end
      if (en && !sa && m_occ < CAP) m_occ++;
      else if (sa && !en && m_occ > 0) m_occ--;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic cycle(input bit ri, input bit ro, input bit en, input bit sa);
      req_in = ri; req_out = ro; entrada = en; salida = sa;
      model_step(ri, ro, en, sa);
      @(posedge clk);
      #1;
      req_in = 0; req_out = 0; entrada = 0; salida = 0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req_in = 0; req_out = 0; entrada = 0; salida = 0;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic check_all(input string tag, input bit g, input bit d, input int c,
                            input bit f, input bit dn, input bit t);
      check({tag, ".gate_open"}, gate_open, g);
      check({tag, ".dir_in"},    dir_in,    d);
      check({tag, ".count"},     count,     c);
      check({tag, ".full"},      full,      f);
      check({tag, ".deny"},      deny,      dn);
      check({tag, ".timeout"},   timeout,   t);
   endtask

   typedef struct {
      bit rst, ri, ro, en, sa;
      bit gate, dir;
      int cnt;
      bit fl, dn, to;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(bit rst, bit ri, bit ro, bit en, bit sa,
                              bit gate, bit dir, int cnt, bit fl, bit dn, bit to);
      vec_t r;
      r.rst = rst; r.ri = ri; r.ro = ro; r.en = en; r.sa = sa;
      r.gate = gate; r.dir = dir; r.cnt = cnt; r.fl = fl; r.dn = dn; r.to = to;
      return r;
   endfunction

   initial begin
      int hi_cnt, to_cnt;

      // entry grant, passage, closing guard, back to idle
      vecs.push_back(v(0,1,0,0,0, 1,1,0,0,0,0));
      vecs.push_back(v(0,0,0,1,0, 0,1,1,0,0,0));
      for (int i = 0; i < 3; i++) vecs.push_back(v(0,0,0,0,0, 0,1,1,0,0,0));
      vecs.push_back(v(0,0,0,0,0, 0,0,1,0,0,0));
      // simultaneous requests after reset: entry first, exit at end of guard
      vecs.push_back(v(1,0,0,0,0, 0,0,0,0,0,0));
      vecs.push_back(v(0,1,1,0,0, 1,1,0,0,0,0));
      vecs.push_back(v(0,0,0,1,0, 0,1,1,0,0,0));
      for (int i = 0; i < 3; i++) vecs.push_back(v(0,0,0,0,0, 0,1,1,0,0,0));
      vecs.push_back(v(0,0,0,0,0, 1,0,1,0,0,0));
      vecs.push_back(v(0,0,0,0,1, 0,0,0,0,0,0));
      for (int i = 0; i < 3; i++) vecs.push_back(v(0,0,0,0,0, 0,0,0,0,0,0));
      vecs.push_back(v(0,0,0,0,0, 0,0,0,0,0,0));

      // reset state
      model_reset();
      #12;
      check_all("reset", 0, 0, 0, 0, 0, 0);
      reset = 1'b1;

      foreach (vecs[i]) begin
         if (vecs[i].rst) do_reset();
         else cycle(vecs[i].ri, vecs[i].ro, vecs[i].en, vecs[i].sa);
         check_all($sformatf("vec%0d", i), vecs[i].gate, vecs[i].dir, vecs[i].cnt,
                   vecs[i].fl, vecs[i].dn, vecs[i].to);
      end

      // fill the lot, refused entries, exit still served
      do_reset();
      for (int i = 0; i < 15; i++) cycle(0, 0, 1, 0);
      check("fill15.full", full, 0);
      cycle(0, 0, 1, 0);
      check("fill16.count", count, 16);
      check("fill16.full", full, 1);
      cycle(0, 0, 1, 0);
      check("sat16.count", count, 16);
      cycle(1, 0, 0, 0);
      check("deny.pulse", deny, 1);
      check("deny.gate", gate_open, 0);
      cycle(0, 0, 0, 0);
      check("deny.end", deny, 0);
      cycle(1, 0, 0, 0);
      check("deny_lvl1", deny, 1);
      cycle(1, 0, 0, 0);
      check("deny_lvl2", deny, 1);
      cycle(0, 0, 0, 0);
      check("deny_lvl.end", deny, 0);
      check("deny_lvl.gate", gate_open, 0);
      cycle(0, 1, 0, 0);
      check("full_exit.gate", gate_open, 1);
      check("full_exit.dir", dir_in, 0);
      cycle(0, 0, 0, 1);
      check("full_exit.count", count, 15);
      check("full_exit.full", full, 0);
      check("full_exit.closed", gate_open, 0);

      // exit grant with no passage times out
      for (int i = 0; i < CLS; i++) cycle(0, 0, 0, 0);
      cycle(0, 1, 0, 0);
      check("to.grant", gate_open, 1);
      hi_cnt = 0; to_cnt = 0;
      for (int i = 1; i < TO; i++) begin
         cycle(0, 0, 0, 0);
         if (gate_open) hi_cnt++;
         if (timeout) to_cnt++;
      end
      check("to.open_cycles", hi_cnt, TO - 1);
      check("to.early_pulse", to_cnt, 0);
      cycle(0, 0, 0, 0);
      check("to.pulse", timeout, 1);
      check("to.gate", gate_open, 0);
      check("to.count", count, 15);
      cycle(0, 0, 0, 0);
      check("to.pulse_end", timeout, 0);

      // cancelling pulses and saturation at zero
      do_reset();
      for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);
      check("five.count", count, 5);
      cycle(0, 0, 1, 1);
      check("both.count", count, 5);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
      check("zero.count", count, 0);
      cycle(0, 0, 0, 1);
      check("sat0.count", count, 0);

      // asynchronous reset while open with an exit pending
      do_reset();
      cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 0);
      cycle(1, 0, 0, 0);
      check("rst_mid.open", gate_open, 1);
      cycle(0, 1, 0, 0);
      check("rst_mid.still_open", gate_open, 1);
      #3;
      reset = 1'b0;
      #1;
      check("rst_mid.gate", gate_open, 0);
      check("rst_mid.dir", dir_in, 0);
      check("rst_mid.count", count, 0);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      hi_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(0, 0, 0, 0);
         if (gate_open) hi_cnt++;
      end
      check("rst_mid.no_grant", hi_cnt, 0);

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         bit ri, ro, en, sa;
         ri = ($urandom_range(0, 4) == 0);
         ro = ($urandom_range(0, 5) == 0);
         en = ($urandom_range(0, 4) == 0);
         sa = ($urandom_range(0, 6) == 0);
         cycle(ri, ro, en, sa);
         check_all($sformatf("rnd%0d", i), m_opened,
                   m_owner_in && (m_opened || m_close_left > 0),
                   m_occ, m_occ == CAP, m_deny, m_to);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
